// File: rtl/shift_pkg.sv
// Shared definitions for the serial right-shift unit: mode codes and FSM states.
package shift_pkg;

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_right_step.sv
// One-position right shift (logical, arithmetic or rotate). Purely combinational.
module shift_right_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] data_out
);

  always_comb begin
    // NOTE: default first so every path assigns data_out and no latch is inferred.
    data_out = {1'b0, data_in[WIDTH-1:1]};
    case (mode)
      MODE_SRA: data_out = {data_in[WIDTH-1], data_in[WIDTH-1:1]};
      MODE_ROR: data_out = {data_in[0], data_in[WIDTH-1:1]};
      default:  data_out = {1'b0, data_in[WIDTH-1:1]};  // SRL and reserved code
    endcase
  end

endmodule

// File: rtl/shift_right_serial.sv
// Multi-cycle right shifter (SRL/SRA/ROR), one bit per clock, valid/ready on both sides.
module shift_right_serial
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   data, data_step;
  logic [SHAMT_W-1:0] count;
  logic [1:0]         mode_q;
  logic               accept;

  assign in_ready  = (state == IDLE) && !flush && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  shift_right_step #(.WIDTH(WIDTH)) u_step (
    .data_in  (data),
    .mode     (mode_q),
    .data_out (data_step)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (count == SHAMT_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Flush wins over an accept or an output transfer in the same cycle.
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state  <= IDLE;
      data   <= '0;
      count  <= '0;
      mode_q <= MODE_SRL;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        count <= '0;
      end else if (accept) begin
        data   <= operand;
        count  <= shamt;
        mode_q <= mode;
        if (shamt == '0) result <= operand;
      end else if (state == SHIFT) begin
        data  <= data_step;
        count <= count - 1'b1;
        if (count == SHAMT_W'(1)) result <= data_step;
      end
    end
  end

endmodule
